// File: rtl/mf_complex_mac_if.sv
// Sample/coefficient/result bundle for the complex matched-filter MAC.
// The master drives the coefficient and sample streams; the slave is the MAC engine.
interface mf_complex_mac_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 46
);
  logic                         enable;
  logic signed [DATA_WIDTH-1:0] coeffInRe;
  logic signed [DATA_WIDTH-1:0] coeffInIm;
  logic                         coeffSetFlag;
  logic                         sampleValid;
  logic signed [DATA_WIDTH-1:0] sampleInRe;
  logic signed [DATA_WIDTH-1:0] sampleInIm;
  logic                         sampleReady;
  logic                         coeffLoaded;
  logic                         loadError;
  logic                         dataOutValid;
  logic signed [ACC_WIDTH-1:0]  dataOutRe;
  logic signed [ACC_WIDTH-1:0]  dataOutIm;

  modport master (
    output enable, coeffInRe, coeffInIm, coeffSetFlag, sampleValid, sampleInRe, sampleInIm,
    input  sampleReady, coeffLoaded, loadError, dataOutValid, dataOutRe, dataOutIm
  );

  modport slave (
    input  enable, coeffInRe, coeffInIm, coeffSetFlag, sampleValid, sampleInRe, sampleInIm,
    output sampleReady, coeffLoaded, loadError, dataOutValid, dataOutRe, dataOutIm
  );
endinterface

// File: rtl/mf_complex_mac.sv
// Serial complex matched filter: captures LENGTH coefficients once per reset, then computes
// one full-precision y[n] = sum h[k]*x[n-k] per accepted sample, one complex MAC per clock.
module mf_complex_mac #(
  parameter int unsigned LENGTH     = 10000,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 46
) (
  input logic             clock,
  input logic             reset,
  mf_complex_mac_if.slave bus
);
  localparam int unsigned AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned CW = $clog2(LENGTH + 3);
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam logic [AW-1:0] LastPtr = AW'(LENGTH - 1);
  localparam logic [CW-1:0] LastIdx = CW'(LENGTH - 1);
  localparam logic [CW-1:0] LenIdx  = CW'(LENGTH);
  localparam logic [CW-1:0] DoneIdx = CW'(LENGTH + 2);

  typedef enum logic [2:0] {StClear, StIdle, StLoad, StReady, StMac} state_e;

  state_e                       r_state;
  logic [CW-1:0]                r_cnt;
  logic                         r_skip;
  logic [AW-1:0]                r_wr_ptr;
  logic [AW-1:0]                r_rd_ptr;
  logic [1:0]                   r_win;
  logic                         r_ready;
  logic                         r_loaded;
  logic                         r_err;
  logic                         r_out_vld;
  logic signed [ACC_WIDTH-1:0]  r_out_re;
  logic signed [ACC_WIDTH-1:0]  r_out_im;
  logic                         r_rd_vld;
  logic                         r_mul_vld;
  logic signed [DATA_WIDTH-1:0] r_rd_hre, r_rd_him, r_rd_xre, r_rd_xim;
  logic signed [PW-1:0]         r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic signed [ACC_WIDTH-1:0]  r_acc_re;
  logic signed [ACC_WIDTH-1:0]  r_acc_im;

  logic signed [DATA_WIDTH-1:0] r_h_re [LENGTH];
  logic signed [DATA_WIDTH-1:0] r_h_im [LENGTH];
  logic signed [DATA_WIDTH-1:0] r_x_re [LENGTH];
  logic signed [DATA_WIDTH-1:0] r_x_im [LENGTH];

  logic                         w_h_we;
  logic                         w_x_we;
  logic                         w_clr;
  logic [AW-1:0]                w_x_addr;
  logic signed [DATA_WIDTH-1:0] w_x_re, w_x_im;
  logic signed [ACC_WIDTH-1:0]  w_rr, w_ii, w_ri, w_ir;

  always_comb begin
    w_clr    = (r_state == StClear);
    w_h_we   = !reset && (r_state == StLoad) && !r_skip;
    w_x_we   = !reset && (w_clr || ((r_state == StReady) && bus.sampleValid));
    w_x_addr = w_clr ? r_cnt[AW-1:0] : r_wr_ptr;
    w_x_re   = w_clr ? '0 : bus.sampleInRe;
    w_x_im   = w_clr ? '0 : bus.sampleInIm;
    w_rr     = ACC_WIDTH'(r_p_rr);
    w_ii     = ACC_WIDTH'(r_p_ii);
    w_ri     = ACC_WIDTH'(r_p_ri);
    w_ir     = ACC_WIDTH'(r_p_ir);
  end

  always_ff @(posedge clock) begin
    if (w_h_we) begin
      r_h_re[r_cnt[AW-1:0]] <= bus.coeffInRe;
      r_h_im[r_cnt[AW-1:0]] <= bus.coeffInIm;
    end
    if (w_x_we) begin
      r_x_re[w_x_addr] <= w_x_re;
      r_x_im[w_x_addr] <= w_x_im;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= StClear;
      r_cnt     <= '0;
      r_skip    <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_win     <= '0;
      r_ready   <= 1'b0;
      r_loaded  <= 1'b0;
      r_err     <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_re  <= '0;
      r_out_im  <= '0;
      r_rd_vld  <= 1'b0;
      r_mul_vld <= 1'b0;
      r_rd_hre  <= '0;
      r_rd_him  <= '0;
      r_rd_xre  <= '0;
      r_rd_xim  <= '0;
      r_p_rr    <= '0;
      r_p_ii    <= '0;
      r_p_ri    <= '0;
      r_p_ir    <= '0;
      r_acc_re  <= '0;
      r_acc_im  <= '0;
    end else begin
      r_out_vld <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_mul_vld <= r_rd_vld;
      if (r_rd_vld) begin
        r_p_rr <= PW'(r_rd_hre) * PW'(r_rd_xre);
        r_p_ii <= PW'(r_rd_him) * PW'(r_rd_xim);
        r_p_ri <= PW'(r_rd_hre) * PW'(r_rd_xim);
        r_p_ir <= PW'(r_rd_him) * PW'(r_rd_xre);
      end
      if (r_mul_vld) begin
        r_acc_re <= r_acc_re + w_rr - w_ii;
        r_acc_im <= r_acc_im + w_ri + w_ir;
      end
      // Done-flag watchdog: the setup stage gets two cycles past the last store to agree.
      if (r_win != 2'd0) begin
        if (bus.coeffSetFlag) begin
          r_win <= '0;
        end else if (r_win == 2'd1) begin
          r_err <= 1'b1;
          r_win <= '0;
        end else begin
          r_win <= r_win - 2'd1;
        end
      end
      case (r_state)
        StClear: begin
          if (r_cnt == LastIdx) begin
            r_cnt   <= '0;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StIdle: begin
          if (bus.enable) begin
            r_cnt   <= '0;
            r_skip  <= 1'b1;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          if (r_skip) begin
            r_skip <= 1'b0;
          end else if (r_cnt == LastIdx) begin
            r_cnt    <= '0;
            r_loaded <= 1'b1;
            r_ready  <= 1'b1;
            r_state  <= StReady;
            if (!bus.coeffSetFlag) r_win <= 2'd2;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StReady: begin
          if (bus.sampleValid) begin
            r_rd_ptr <= r_wr_ptr;
            r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + AW'(1);
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_state  <= StMac;
          end
        end
        StMac: begin
          if (r_cnt < LenIdx) begin
            r_rd_hre <= r_h_re[r_cnt[AW-1:0]];
            r_rd_him <= r_h_im[r_cnt[AW-1:0]];
            r_rd_xre <= r_x_re[r_rd_ptr];
            r_rd_xim <= r_x_im[r_rd_ptr];
            r_rd_vld <= 1'b1;
            r_rd_ptr <= (r_rd_ptr == '0) ? LastPtr : r_rd_ptr - AW'(1);
          end
          // Two extra cycles let the multiply and accumulate stages drain.
          if (r_cnt == DoneIdx) begin
            r_out_vld <= 1'b1;
            r_out_re  <= r_acc_re;
            r_out_im  <= r_acc_im;
            r_ready   <= 1'b1;
            r_cnt     <= '0;
            r_state   <= StReady;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= StClear;
      endcase
    end
  end

  assign bus.sampleReady  = r_ready;
  assign bus.coeffLoaded  = r_loaded;
  assign bus.loadError    = r_err;
  assign bus.dataOutValid = r_out_vld;
  assign bus.dataOutRe    = r_out_re;
  assign bus.dataOutIm    = r_out_im;
endmodule

// File: tb/tb_mf_complex_mac.sv
// Randomized bench for mf_complex_mac at LENGTH=4: a convolution model over the full sample
// history predicts every result, its strobe cycle, and the ready/loaded flags each clock.
module tb_mf_complex_mac;
  localparam int L    = 4;
  localparam int DW   = 16;
  localparam int ACCW = 46;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mf_complex_mac_if #(.DATA_WIDTH(DW), .ACC_WIDTH(ACCW)) bus ();

  mf_complex_mac #(.LENGTH(L), .DATA_WIDTH(DW), .ACC_WIDTH(ACCW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  bit     m_loaded, m_load_pending, m_pending, m_accepted;
  int     m_e, m_idle_from, m_ready_cyc, m_exp_cyc;
  longint m_exp_re, m_exp_im;
  int     m_h_re [L];
  int     m_h_im [L];
  int     m_x_re [$];
  int     m_x_im [$];
  int     t_h_re [L];
  int     t_h_im [L];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", tag, cyc, obs, exp);
    end
  endtask

  // One rising edge: model the edge from the driven inputs, then compare outputs.
  task automatic step();
    bit     rst_now, acc, en_seen, exp_vld;
    int     nxt, n, sre, sim;
    longint yr, yi;
    rst_now = (reset === 1'b1);
    nxt     = cyc + 1;
    sre     = int'(bus.sampleInRe);
    sim     = int'(bus.sampleInIm);
    acc     = !rst_now && bus.sampleValid && m_loaded && (cyc >= m_ready_cyc);
    en_seen = !rst_now && bus.enable && !m_loaded && !m_load_pending && (cyc >= m_idle_from);
    if (!rst_now && m_load_pending && nxt >= m_e + 2 && nxt <= m_e + L + 1) begin
      m_h_re[nxt - m_e - 2] = int'(bus.coeffInRe);
      m_h_im[nxt - m_e - 2] = int'(bus.coeffInIm);
    end
    @(posedge clock);
    #1;
    cyc = nxt;
    if (rst_now) begin
      m_loaded       = 1'b0;
      m_load_pending = 1'b0;
      m_pending      = 1'b0;
      m_x_re.delete();
      m_x_im.delete();
      m_idle_from    = cyc + L;
    end else begin
      if (en_seen) begin
        m_load_pending = 1'b1;
        m_e            = cyc;
      end
      if (m_load_pending && cyc == m_e + L + 1) begin
        m_load_pending = 1'b0;
        m_loaded       = 1'b1;
        m_ready_cyc    = cyc;
      end
      if (acc) begin
        m_x_re.push_back(sre);
        m_x_im.push_back(sim);
        n  = m_x_re.size() - 1;
        yr = 0;
        yi = 0;
        for (int k = 0; k < L; k++) begin
          if (n - k >= 0) begin
            yr += longint'(m_h_re[k]) * m_x_re[n-k] - longint'(m_h_im[k]) * m_x_im[n-k];
            yi += longint'(m_h_re[k]) * m_x_im[n-k] + longint'(m_h_im[k]) * m_x_re[n-k];
          end
        end
        m_exp_re    = yr;
        m_exp_im    = yi;
        m_pending   = 1'b1;
        m_exp_cyc   = cyc + L + 3;
        m_ready_cyc = m_exp_cyc;
        m_accepted  = 1'b1;
      end
    end
    exp_vld = m_pending && (cyc == m_exp_cyc);
    check("valid", 64'(bus.dataOutValid), 64'(exp_vld));
    if (exp_vld) begin
      check("out_re", bus.dataOutRe, m_exp_re);
      check("out_im", bus.dataOutIm, m_exp_im);
      m_pending = 1'b0;
    end
    check("ready", 64'(bus.sampleReady), 64'(m_loaded && cyc >= m_ready_cyc));
    check("loaded", 64'(bus.coeffLoaded), 64'(m_loaded));
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.coeffSetFlag = 1'b0;
    step();
    step();
    reset = 1'b0;
    repeat (L) step();
  endtask

  // flag_mode: 0 = done flag with last word, 1 = one cycle late, 2 = never
  task automatic load_coeffs(input int flag_mode);
    bus.enable = 1'b1;
    step();
    bus.enable    = 1'b0;
    bus.coeffInRe = 16'($urandom);
    bus.coeffInIm = 16'($urandom);
    step();
    for (int k = 0; k < L; k++) begin
      bus.coeffInRe = 16'(t_h_re[k]);
      bus.coeffInIm = 16'(t_h_im[k]);
      if (k == L - 1 && flag_mode == 0) bus.coeffSetFlag = 1'b1;
      step();
    end
    bus.coeffInRe = 16'($urandom);
    bus.coeffInIm = 16'($urandom);
    if (flag_mode == 1) bus.coeffSetFlag = 1'b1;
    repeat (3) step();
    check("load_error", 64'(bus.loadError), 64'(flag_mode == 2));
  endtask

  task automatic send(input int re, input int im);
    m_accepted     = 1'b0;
    bus.sampleValid = 1'b1;
    bus.sampleInRe  = 16'(re);
    bus.sampleInIm  = 16'(im);
    for (int i = 0; i < 40 && !m_accepted; i++) step();
    bus.sampleValid = 1'b0;
    if (!m_accepted) check("accept_timeout", 64'd0, 64'd1);
    for (int i = 0; i < L + 8 && m_pending; i++) step();
    if (m_pending) check("result_timeout", 64'd0, 64'd1);
  endtask

  task automatic set_h(input int k, input int re, input int im);
    t_h_re[k] = re;
    t_h_im[k] = im;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.enable      = 1'b0;
    bus.coeffInRe   = '0;
    bus.coeffInIm   = '0;
    bus.coeffSetFlag = 1'b0;
    bus.sampleValid = 1'b0;
    bus.sampleInRe  = '0;
    bus.sampleInIm  = '0;

    // Basic load and two samples
    do_reset();
    set_h(0, 1, 0); set_h(1, 0, 1); set_h(2, 2, -1); set_h(3, -3, 2);
    load_coeffs(0);
    send(1, 1);
    send(2, 0);
    check("y1_re", bus.dataOutRe, 64'sd1);
    check("y1_im", bus.dataOutIm, 64'sd1);

    // Impulse response with pointer wrap and ageing out
    do_reset();
    load_coeffs(0);
    send(1, 0);
    repeat (5) send(0, 0);

    // Largest-magnitude products accumulate without overflow
    do_reset();
    for (int k = 0; k < L; k++) set_h(k, -32768, 0);
    load_coeffs(0);
    repeat (4) send(-32768, 0);
    check("big_re", bus.dataOutRe, 64'sd4294967296);
    check("big_im", bus.dataOutIm, 64'sd0);

    // Reset mid-MAC aborts the result and drops the coefficients
    do_reset();
    set_h(0, 1, 0); set_h(1, 0, 1); set_h(2, 2, -1); set_h(3, -3, 2);
    load_coeffs(0);
    m_accepted      = 1'b0;
    bus.sampleValid = 1'b1;
    bus.sampleInRe  = 16'(3);
    bus.sampleInIm  = 16'(-2);
    for (int i = 0; i < 40 && !m_accepted; i++) step();
    step();
    step();
    do_reset();
    repeat (3) step();
    bus.sampleValid = 1'b0;
    load_coeffs(0);
    send(5, 5);

    // Back-to-back samples with stray enables during READY/MAC
    bus.sampleValid = 1'b1;
    for (int i = 0; i < 42; i++) begin
      bus.sampleInRe = 16'($urandom);
      bus.sampleInIm = 16'($urandom);
      bus.enable     = (i >= 7 && i < 15);
      if (bus.enable) begin
        bus.coeffInRe = 16'($urandom);
        bus.coeffInIm = 16'($urandom);
      end
      step();
    end
    bus.enable      = 1'b0;
    bus.sampleValid = 1'b0;
    for (int i = 0; i < L + 8 && m_pending; i++) step();
    if (m_pending) check("drain_timeout", 64'd0, 64'd1);

    // Random coefficients and samples with random idle gaps
    do_reset();
    for (int k = 0; k < L; k++) set_h(k, int'($signed(16'($urandom))), int'($signed(16'($urandom))));
    load_coeffs(0);
    for (int s = 0; s < 25; s++) begin
      repeat ($urandom_range(0, 2)) step();
      send(int'($signed(16'($urandom))), int'($signed(16'($urandom))));
    end

    // Done flag late by one cycle is tolerated; missing flag is sticky but not fatal
    do_reset();
    load_coeffs(1);
    send(7, -7);
    do_reset();
    load_coeffs(2);
    send(-4, 9);
    check("load_error_sticky", 64'(bus.loadError), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
